// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified inst/data RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_D  = 1'b1;
    localparam logic [3:0] WE_ALL = 4'b1111;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant selection between fetch and data ports.
// ARB_ROUND_ROBIN_EN: ties go to rr_ptr instead of the data port.
module arb_grant_sel
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic rr_ptr,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = if_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    assign grant_owner = (if_req && d_req) ? rr_ptr : (d_req ? OWN_D : OWN_IF);
`else
    logic unused_rr;
    assign unused_rr   = rr_ptr;
    assign grant_owner = d_req ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port synchronous RAM.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: data beats fetch).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int RAM_LAT = 1
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          stall,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    arb_state_t    state;
    logic [CW-1:0] cnt;
    logic          cur_owner;
    logic          cur_we;
    logic          rr_ptr;
    logic          sel_if, sel_d;
    logic          grant_valid, grant_owner, grant_we;
    logic          arb_slot;

    assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);
    assign arb_slot = (state == IDLE) || (state == DONE);
    assign grant_we = (grant_owner == OWN_D) & d_we;

    // A port whose ack is in flight still shows req this cycle; don't serve it twice.
    always_comb begin
        sel_if = if_req & ~if_ack;
        sel_d  = d_req & ~d_ack;
        if (state == DONE) begin
            if (cur_owner == OWN_IF) sel_if = 1'b0;
            else                     sel_d  = 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // rr_ptr names the port favoured on the next tie.
    always_ff @(posedge clka or posedge rst) begin
        if (rst)                          rr_ptr <= OWN_D;
        else if (arb_slot && grant_valid) rr_ptr <= ~grant_owner;
    end
`else
    assign rr_ptr = OWN_D;
`endif

    arb_grant_sel u_sel (
        .if_req      (sel_if),
        .d_req       (sel_d),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_owner <= OWN_IF;
            cur_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= '0;
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: ;
                ISSUE: begin
                    if (RAM_LAT == 1) begin
                        state <= DONE;
                    end else begin
                        cnt   <= CW'(RAM_LAT - 1);
                        state <= WAIT;
                    end
                end
                // Leaving on cnt==1 puts DONE exactly RAM_LAT cycles after ram_en.
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    if (cur_owner == OWN_D) begin
                        d_ack <= 1'b1;
                        if (!cur_we) d_rdata <= ram_rdata;
                    end else begin
                        if_ack <= 1'b1;
                        if (!cur_we) if_rdata <= ram_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (arb_slot && grant_valid) begin
                state     <= ISSUE;
                cur_owner <= grant_owner;
                cur_we    <= grant_we;
                ram_en    <= 1'b1;
                ram_we    <= grant_we ? WE_ALL : 4'b0000;
                ram_addr  <= (grant_owner == OWN_D) ? d_addr : if_addr;
                ram_wdata <= (grant_owner == OWN_D) ? d_wdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM_LAT=1 and RAM_LAT=3 instances, each with its own RAM.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam bit P_IF = 1'b0;
    localparam bit P_D  = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          if_req [2], d_req [2], d_we [2], if_ack [2], d_ack [2], stall [2], ram_en [2];
    logic [AW-1:0] if_addr [2], d_addr [2], ram_addr [2];
    logic [DW-1:0] d_wdata [2], if_rdata [2], d_rdata [2], ram_wdata [2], ram_rdata [2];
    logic [3:0]    ram_we [2];

    logic [DW-1:0] model_mem [2][1024];
    bit            fav [2];
    int            vectors = 0;
    int            errors  = 0;

    function automatic logic [DW-1:0] init_val(int k, int a);
        return DW'(32'h2002_0000 + (k << 24) + a);
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit first_of(int k);
`ifdef ARB_ROUND_ROBIN_EN
        return fav[k];
`else
        return (k >= 0) ? P_D : P_IF;
`endif
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem  [1024];
        logic [DW-1:0] pipe [4];

        initial for (int i = 0; i < 1024; i++) mem[i] = init_val(g, i);

        // Read data emerges LAT cycles after en; garbage otherwise to expose mistimed captures.
        always @(posedge clk) begin
            if (ram_en[g] && ram_we[g] == 4'hF) mem[ram_addr[g]] <= ram_wdata[g];
            pipe[0] <= ram_en[g] ? mem[ram_addr[g]] : DW'($urandom);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_rdata[g] = pipe[LAT-1];

        mem_port_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(LAT)) u_dut (
            .clka      (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_ack    (if_ack[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_rdata   (d_rdata[g]),
            .d_ack     (d_ack[g]),
            .stall     (stall[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g])
        );
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 0; d_req[k] = 0; d_we[k] = 0;
            if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
            fav[k] = P_D;
        end
        for (int k = 0; k < 2; k++) for (int a = 0; a < 1024; a++) model_mem[k][a] = init_val(k, a);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({ram_en[k], ram_we[k], ram_addr[k], ram_wdata[k]} !== '0) begin
                errors++; $display("FAIL reset_ram[%0d]: got %0h want 0", k, {ram_en[k], ram_we[k], ram_addr[k], ram_wdata[k]});
            end
            vectors++;
            if ({if_ack[k], d_ack[k], stall[k], if_rdata[k], d_rdata[k]} !== '0) begin
                errors++; $display("FAIL reset_port[%0d]: got %0h want 0", k, {if_ack[k], d_ack[k], stall[k], if_rdata[k], d_rdata[k]});
            end
        end
        rst = 1'b0;
    endtask

    // Single access on an idle arbiter: ram_en at cycle 1, ack at cycle RAM_LAT+2.
    task automatic do_access(input int k, input bit port, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input string tag);
        int lat;
        logic ack_p, ack_o;
        logic [DW-1:0] keep_if, keep_d, got_own, got_oth, exp_own, exp_oth;
        lat = lat_of(k);
        keep_if = if_rdata[k];
        keep_d  = d_rdata[k];
        @(posedge clk); #1;
        if (port == P_D) begin d_req[k] = 1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata; end
        else begin if_req[k] = 1; if_addr[k] = addr; end
        for (int c = 0; c < lat + 5; c++) begin
            @(negedge clk);
            ack_p = (port == P_D) ? d_ack[k] : if_ack[k];
            ack_o = (port == P_D) ? if_ack[k] : d_ack[k];
            vectors++;
            if (ram_en[k] !== (c == 1)) begin errors++; $display("FAIL %s ram_en c%0d: got %b want %b", tag, c, ram_en[k], c == 1); end
            vectors++;
            if (ack_p !== (c == lat + 2)) begin errors++; $display("FAIL %s ack c%0d: got %b want %b", tag, c, ack_p, c == lat + 2); end
            vectors++;
            if (ack_o !== 1'b0) begin errors++; $display("FAIL %s other_ack c%0d: got %b want 0", tag, c, ack_o); end
            vectors++;
            if (stall[k] !== (c < lat + 2)) begin errors++; $display("FAIL %s stall c%0d: got %b want %b", tag, c, stall[k], c < lat + 2); end
            if (c == 1) begin
                vectors++;
                if (ram_addr[k] !== addr) begin errors++; $display("FAIL %s ram_addr: got %0h want %0h", tag, ram_addr[k], addr); end
                vectors++;
                if (ram_we[k] !== (we ? 4'hF : 4'h0)) begin errors++; $display("FAIL %s ram_we: got %h want %h", tag, ram_we[k], we ? 4'hF : 4'h0); end
                if (we) begin
                    vectors++;
                    if (ram_wdata[k] !== wdata) begin errors++; $display("FAIL %s ram_wdata: got %h want %h", tag, ram_wdata[k], wdata); end
                end
            end
            if (c == lat + 2) begin
                got_own = (port == P_D) ? d_rdata[k] : if_rdata[k];
                got_oth = (port == P_D) ? if_rdata[k] : d_rdata[k];
                exp_own = we ? keep_d : model_mem[k][addr];
                exp_oth = (port == P_D) ? keep_if : keep_d;
                vectors++;
                if (got_own !== exp_own) begin errors++; $display("FAIL %s rdata: got %h want %h", tag, got_own, exp_own); end
                vectors++;
                if (got_oth !== exp_oth) begin errors++; $display("FAIL %s other_rdata: got %h want %h", tag, got_oth, exp_oth); end
                if (we) model_mem[k][addr] = wdata;
                if_req[k] = 0; d_req[k] = 0;
            end
        end
        fav[k] = ~port;
    endtask

    task automatic test_simultaneous();
        bit first;
        int lat, t1, t2;
        lat = lat_of(0);
        first = first_of(0);
        t1 = lat + 2;
        t2 = 2 * lat + 3;
        @(posedge clk); #1;
        if_req[0] = 1; if_addr[0] = 5; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 8;
        for (int c = 0; c < t2 + 3; c++) begin
            @(negedge clk);
            vectors++;
            if (d_ack[0] !== (c == ((first == P_D) ? t1 : t2))) begin errors++; $display("FAIL simul d_ack c%0d: got %b", c, d_ack[0]); end
            vectors++;
            if (if_ack[0] !== (c == ((first == P_IF) ? t1 : t2))) begin errors++; $display("FAIL simul if_ack c%0d: got %b", c, if_ack[0]); end
            vectors++;
            if (stall[0] !== (c < t2)) begin errors++; $display("FAIL simul stall c%0d: got %b want %b", c, stall[0], c < t2); end
            if (d_ack[0] === 1'b1) begin
                vectors++;
                if (d_rdata[0] !== model_mem[0][8]) begin errors++; $display("FAIL simul d_rdata: got %h want %h", d_rdata[0], model_mem[0][8]); end
                d_req[0] = 0;
            end
            if (if_ack[0] === 1'b1) begin
                vectors++;
                if (if_rdata[0] !== model_mem[0][5]) begin errors++; $display("FAIL simul if_rdata: got %h want %h", if_rdata[0], model_mem[0][5]); end
                if_req[0] = 0;
            end
        end
        fav[0] = first;
    endtask

    task automatic test_back_to_back();
        bit first, owner, exp_owner;
        int lat, n_ack, last_c, n_if, n_d;
        lat = lat_of(0);
        first = first_of(0);
        n_ack = 0; last_c = 0; n_if = 0; n_d = 0;
        @(posedge clk); #1;
        if_req[0] = 1; if_addr[0] = 5; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 12;
        for (int c = 0; c < 80 && n_ack < 8; c++) begin
            @(negedge clk);
            if (if_ack[0] === 1'b1 || d_ack[0] === 1'b1) begin
                owner = (d_ack[0] === 1'b1) ? P_D : P_IF;
                exp_owner = (n_ack % 2 == 0) ? first : ~first;
                vectors++;
                if (owner !== exp_owner) begin errors++; $display("FAIL b2b owner #%0d: got %b want %b", n_ack, owner, exp_owner); end
                if (n_ack > 0) begin
                    vectors++;
                    if (c - last_c > 2 * (lat + 1)) begin errors++; $display("FAIL b2b gap #%0d: got %0d want <=%0d", n_ack, c - last_c, 2 * (lat + 1)); end
                end
                vectors++;
                if (owner == P_D && d_rdata[0] !== model_mem[0][12]) begin errors++; $display("FAIL b2b d_rdata: got %h want %h", d_rdata[0], model_mem[0][12]); end
                else if (owner == P_IF && if_rdata[0] !== model_mem[0][5]) begin errors++; $display("FAIL b2b if_rdata: got %h want %h", if_rdata[0], model_mem[0][5]); end
                if (owner == P_D) n_d++; else n_if++;
                last_c = c;
                n_ack++;
            end
        end
        if_req[0] = 0; d_req[0] = 0;
        vectors++;
        if (n_if != 4 || n_d != 4) begin errors++; $display("FAIL b2b share: got if=%0d d=%0d want 4/4", n_if, n_d); end
        repeat (3 * (lat + 1) + 2) @(posedge clk);
    endtask

    task automatic test_reset_mid_wait();
        logic ack_k;
        @(posedge clk); #1;
        d_req[1] = 1; d_we[1] = 0; d_addr[1] = 8;
        @(posedge clk); #1;
        if_req[0] = 1; if_addr[0] = 7;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ram_en[0] !== 1'b1) begin errors++; $display("FAIL rstmid pre_en: got %b want 1", ram_en[0]); end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({ram_en[k], ram_we[k], ram_addr[k], ram_wdata[k], if_ack[k], d_ack[k], if_rdata[k], d_rdata[k]} !== '0) begin
                errors++; $display("FAIL rstmid async[%0d]: got %0h want 0", k,
                    {ram_en[k], ram_we[k], ram_addr[k], ram_wdata[k], if_ack[k], d_ack[k], if_rdata[k], d_rdata[k]});
            end
        end
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if ({if_ack[0], d_ack[0], if_ack[1], d_ack[1]} !== 4'b0) begin errors++; $display("FAIL rstmid ack_in_reset: got %b want 0", {if_ack[0], d_ack[0], if_ack[1], d_ack[1]}); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        fav[0] = P_D; fav[1] = P_D;
        for (int c = 0; c < lat_of(1) + 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                ack_k = (k == 0) ? if_ack[0] : d_ack[1];
                vectors++;
                if (ack_k !== (c == lat_of(k) + 2)) begin errors++; $display("FAIL rstmid reserve_ack[%0d] c%0d: got %b", k, c, ack_k); end
            end
            if (if_ack[0] === 1'b1) begin
                vectors++;
                if (if_rdata[0] !== model_mem[0][7]) begin errors++; $display("FAIL rstmid if_rdata: got %h want %h", if_rdata[0], model_mem[0][7]); end
                if_req[0] = 0;
            end
            if (d_ack[1] === 1'b1) begin
                vectors++;
                if (d_rdata[1] !== model_mem[1][8]) begin errors++; $display("FAIL rstmid d_rdata: got %h want %h", d_rdata[1], model_mem[1][8]); end
                d_req[1] = 0;
            end
        end
        fav[0] = P_D; fav[1] = P_IF;
    endtask

    // Independent requester; fetch stays in 0..255, data in 256..511, so order across ports never matters.
    task automatic req_thread(input int k, input bit port, input int n);
        int lat, c;
        bit acked, we;
        logic ack;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, got;
        lat = lat_of(k);
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            if (port == P_D) begin
                we = 1'($urandom_range(0, 1));
                a  = AW'(256 + $urandom_range(0, 255));
                wd = DW'($urandom);
                d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1;
            end else begin
                we = 0; wd = '0;
                a = AW'($urandom_range(0, 255));
                if_addr[k] = a; if_req[k] = 1;
            end
            c = 0; acked = 0;
            while (!acked && c <= 2 * lat + 4) begin
                @(negedge clk);
                ack = (port == P_D) ? d_ack[k] : if_ack[k];
                if (ack === 1'b1) acked = 1;
                else c++;
            end
            vectors++;
            if (!acked || c < lat + 2 || c > 2 * lat + 3) begin
                errors++; $display("FAIL rand[%0d,%0d] latency: got %0d (acked=%0b) want %0d..%0d", k, port, c, acked, lat + 2, 2 * lat + 3);
            end
            if (acked && !we) begin
                got = (port == P_D) ? d_rdata[k] : if_rdata[k];
                vectors++;
                if (got !== model_mem[k][a]) begin errors++; $display("FAIL rand[%0d,%0d] rdata @%0h: got %h want %h", k, port, a, got, model_mem[k][a]); end
            end
            if (we) model_mem[k][a] = wd;
            if (port == P_D) d_req[k] = 0; else if_req[k] = 0;
        end
    endtask

    task automatic test_random();
        fork
            req_thread(0, P_IF, 25);
            req_thread(0, P_D, 25);
            req_thread(1, P_IF, 25);
            req_thread(1, P_D, 25);
        join
        repeat (10) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        do_access(0, P_IF, 1'b0, 10'd5, '0, "single_fetch");
        do_access(0, P_D, 1'b1, 10'd8, 32'hDEAD_BEEF, "d_write");
        do_access(0, P_D, 1'b0, 10'd8, '0, "d_read");
        do_access(1, P_D, 1'b0, 10'd8, '0, "lat3_read");
        do_access(1, P_IF, 1'b0, 10'd1023, '0, "lat3_fetch_top");
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
